// File: rtl/dbg_loader_pkg.sv
// Shared types and constants for the debug program loader: FSM states,
// command byte encodings and the instruction word geometry.
package dbg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_BYTE,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_RUN
    } state_e;

    localparam logic [7:0] CMD_LOAD    = 8'hA5;
    localparam logic [7:0] CMD_RUN     = 8'h5A;
    localparam logic [7:0] CMD_CLR_ERR = 8'hC3;

    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = $clog2(WORD_BYTES);

    // States in which the write handshake owns addr/instr and no byte may be taken.
    function automatic logic is_stall(state_e s);
        return (s == ST_SETUP) || (s == ST_WRITE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects WORD_BYTES payload bytes into one little-endian word; the first
// byte received lands in bits [7:0]. word_done_o flags the final byte.
module byte_word_assembler
    import dbg_loader_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            shift_i,
    input  logic [7:0]      byte_i,
    output logic [XLEN-1:0] word_o,
    output logic            word_done_o
);

    logic [IDX_W-1:0] idx_q;
    logic [XLEN-1:0]  word_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            idx_q  <= '0;
        end else if (shift_i) begin
            // Shifting right means the earliest byte ends up lowest after 4 shifts.
            word_q <= {byte_i, word_q[XLEN-1:8]};
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign word_o      = word_q;
    assign word_done_o = shift_i && (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/dbg_loader.sv
// Byte-stream debug loader for cpuCore: parses LOAD/RUN/CLR_ERR commands,
// writes assembled instruction words through the debug port, gates core reset.
module dbg_loader
    import dbg_loader_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BASE_ADDR = 0,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            rx_ready,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    output logic            core_rst,
    output logic            busy,
    output logic            err
);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cnt_lo_q, cnt_lo_d;
    logic             core_rst_q, core_rst_d;
    logic             err_q, err_d;
    logic             wr_en_q, busy_q;
    logic             accept;
    logic             asm_clr, asm_shift, word_done;
    logic [CNT_W-1:0] cnt_new;

    assign rx_ready = !is_stall(state_q);
    assign accept   = rx_valid && rx_ready;
    assign cnt_new  = CNT_W'({rx_data, cnt_lo_q});

    byte_word_assembler #(.XLEN(XLEN)) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (asm_clr),
        .shift_i     (asm_shift),
        .byte_i      (rx_data),
        .word_o      (dbg_instr),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        cnt_lo_d   = cnt_lo_q;
        core_rst_d = core_rst_q;
        err_d      = err_q;
        asm_clr    = 1'b0;
        asm_shift  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    if (rx_data == CMD_LOAD) begin
                        core_rst_d = 1'b1;
                        addr_d     = XLEN'(BASE_ADDR);
                        asm_clr    = 1'b1;
                        state_d    = ST_CNT_LO;
                    end else if (rx_data == CMD_RUN) begin
                        state_d    = ST_RUN;
                        core_rst_d = 1'b0;
                    end else if (rx_data == CMD_CLR_ERR) begin
                        err_d      = 1'b0;
                    end else begin
                        err_d      = 1'b1;
                    end
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    cnt_lo_d = rx_data;
                    state_d  = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (accept) begin
                    cnt_d   = cnt_new;
                    state_d = (cnt_new == '0) ? ST_IDLE : ST_BYTE;
                end
            end
            ST_BYTE: begin
                asm_shift = accept;
                if (word_done) state_d = ST_SETUP;
            end
            ST_SETUP: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_HOLD;
            ST_HOLD: begin
                // Address advances only on leaving HOLD so the core sees stable
                // addr/instr across the whole setup-strobe-hold window.
                addr_d  = addr_q + XLEN'(WORD_BYTES);
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? ST_IDLE : ST_BYTE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            cnt_lo_q   <= '0;
            core_rst_q <= 1'b1;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            cnt_lo_q   <= cnt_lo_d;
            core_rst_q <= core_rst_d;
            err_q      <= err_d;
            wr_en_q    <= (state_d == ST_WRITE);
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_RUN);
        end
    end

    assign dbg_wr_en = wr_en_q;
    assign dbg_addr  = addr_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dbg_loader.sv
// Scoreboard bench for dbg_loader: stimulus pushes expected writes, a negedge
// monitor pops and checks each dbg_wr_en pulse.
module tb_dbg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, dbg_wr_en, core_rst, busy, err;
    logic [31:0] dbg_addr, dbg_instr;

    dbg_loader #(.XLEN(32), .BASE_ADDR(0), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .dbg_wr_en (dbg_wr_en),
        .dbg_addr  (dbg_addr),
        .dbg_instr (dbg_instr),
        .core_rst  (core_rst),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   tests = 0;
    int   fails = 0;
    int   stall_cnt = 0;
    logic prev_wr = 1'b0;
    logic gaps = 1'b0;

    logic [31:0] prog [4] = '{32'h002081B3, 32'h00310093, 32'h002081BB, 32'h0031009B};

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rx_ready) stall_cnt++;
        if (dbg_wr_en) begin
            tests++;
            if (prev_wr) begin
                fails++;
                $display("FAIL wr_en_double: dbg_wr_en high 2 cycles at t=%0t", $time);
            end
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write: addr=%h instr=%h, no write expected", dbg_addr, dbg_instr);
            end else begin
                mon_e = exp_q.pop_front();
                tests++;
                if (dbg_addr !== mon_e.addr) begin
                    fails++;
                    $display("FAIL wr_addr: got %h expected %h", dbg_addr, mon_e.addr);
                end
                tests++;
                if (dbg_instr !== mon_e.instr) begin
                    fails++;
                    $display("FAIL wr_instr: got %h expected %h", dbg_instr, mon_e.instr);
                end
            end
        end
        prev_wr = dbg_wr_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one byte and hold it until the DUT takes it; returns at posedge+1.
    task automatic send(input logic [7:0] b);
        logic done;
        done = 1'b0;
        if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready=%b", b, rx_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]); send(w[15:8]); send(w[23:16]); send(w[31:24]);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_rx_ready"}, 32'(rx_ready), 32'd1);
        chk({name, "_wr_en"}, 32'(dbg_wr_en), 32'd0);
        chk({name, "_addr"}, dbg_addr, 32'h0);
        chk({name, "_instr"}, dbg_instr, 32'h0);
        chk({name, "_core_rst"}, 32'(core_rst), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;

        // Single word load, core stays in reset.
        exp_q.push_back('{addr: 32'h0, instr: 32'h002081B3});
        send(8'hA5); send(8'h01); send(8'h00);
        send_word(32'h002081B3);
        wait_idle("load1");
        chk("load1_core_rst", 32'(core_rst), 32'd1);

        // Four-word load then RUN.
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 32'(4 * i), instr: prog[i]});
        send(8'hA5); send(8'h04); send(8'h00);
        for (int i = 0; i < 4; i++) send_word(prog[i]);
        wait_idle("load4");
        chk("load4_stalls", 32'(stall_cnt), 32'd12);
        chk("pre_run_core_rst", 32'(core_rst), 32'd1);
        send(8'h5A);
        chk("run_core_rst", 32'(core_rst), 32'd0);

        // LOAD issued while running, with random valid gaps.
        gaps = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 32'(4 * i), instr: prog[i]});
        send(8'hA5);
        chk("reload_core_rst_rise", 32'(core_rst), 32'd1);
        chk("reload_busy", 32'(busy), 32'd1);
        send(8'h04); send(8'h00);
        for (int i = 0; i < 4; i++) send_word(prog[i]);
        wait_idle("gaps");
        gaps = 1'b0;
        chk("gaps_stalls", 32'(stall_cnt), 32'd12);
        chk("gaps_core_rst_held", 32'(core_rst), 32'd1);
        send(8'h5A);
        chk("rerun_core_rst", 32'(core_rst), 32'd0);

        // Zero-length load, bad command, clear error.
        send(8'hA5); send(8'h00); send(8'h00);
        wait_idle("zero");
        chk("zero_core_rst", 32'(core_rst), 32'd1);
        send(8'h77);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_rx_ready", 32'(rx_ready), 32'd1);
        chk("bad_core_rst", 32'(core_rst), 32'd1);
        send(8'h77);
        chk("bad2_err_sticky", 32'(err), 32'd1);
        send(8'hC3);
        chk("clr_err", 32'(err), 32'd0);

        // Reset in the middle of a word: nothing gets written.
        send(8'h77);
        send(8'hA5); send(8'h01); send(8'h00); send(8'hB3); send(8'h81);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_write_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        exp_q.push_back('{addr: 32'h0, instr: 32'h0031009B});
        send(8'hA5); send(8'h01); send(8'h00);
        send_word(32'h0031009B);
        wait_idle("fresh");
        chk("fresh_next_addr", dbg_addr, 32'h4);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbg_loader.md
# dbg_loader

Debug program loader that drives the instruction-memory debug write port of `cpuCore` from a byte stream. It parses load and run commands, assembles little-endian 32-bit instruction words, and issues one-cycle `dbg_wr_en` pulses with auto-incrementing word addresses. It holds the core in reset while loading and releases it on command. It sits between a host byte source (UART receiver or JTAG bridge) and `cpuCore`'s `dbg_wr_en`/`dbg_addr`/`dbg_instr`/`rst` inputs.

## Interface
- XLEN, 32, address/instruction width; only 32 supported
- BASE_ADDR, 0, byte address of first word written by each load
- CNT_W, 16, width of the word-count field
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-low
- rx_valid  input  1  byte available on rx_data
- rx_data  input  8  command/payload byte
- rx_ready  output  1  loader accepts byte this cycle
- dbg_wr_en  output  1  instruction-memory write strobe, to cpuCore
- dbg_addr  output  XLEN  byte address of write, to cpuCore
- dbg_instr  output  XLEN  instruction word, to cpuCore
- core_rst  output  1  active-high reset to cpuCore `rst`
- busy  output  1  load in progress (any state other than IDLE/RUN)
- err  output  1  sticky: unknown command byte received

## Operation
- Byte transfer: accepted on rising clk when rx_valid && rx_ready. rx_ready decoded from state: 1 in IDLE, CNT_LO, CNT_HI, BYTE, RUN; 0 in SETUP, WRITE, HOLD.
- Commands (accepted in IDLE or RUN): 0xA5 LOAD, 0x5A RUN, 0xC3 CLR_ERR. Any other byte: consumed, err set, state unchanged.
- LOAD: core_rst set 1, dbg_addr set to BASE_ADDR, go to CNT_LO. The next two bytes form count N (low byte first). N=0 returns to IDLE with no writes.
- BYTE: four bytes shift into dbg_instr little-endian (first byte to [7:0]). On the 4th byte go to SETUP.
- SETUP: addr/instr stable, dbg_wr_en 0. WRITE: dbg_wr_en 1 for exactly one cycle. HOLD: dbg_wr_en 0, addr/instr still stable. Then dbg_addr += 4 (mod 2^XLEN) and the remaining count decrements. Go to BYTE if words remain, else IDLE.
- RUN command in IDLE: go to RUN, core_rst 0 from the next cycle. RUN received while in RUN: no-op. LOAD received while in RUN: core_rst reasserted and a new load starts.
- CLR_ERR clears err; it is the only way to clear err other than reset.
- States: IDLE, CNT_LO, CNT_HI, BYTE, SETUP, WRITE, HOLD, RUN.

## Timing
- Reset values: state IDLE, rx_ready 1, dbg_wr_en 0, dbg_addr 0, dbg_instr 0, core_rst 1, busy 0, err 0, byte index 0, count 0.
- Reset asserted mid-load: abort immediately to the reset values. A partial word is never written.
- All outputs registered except rx_ready.
- Per word: 4 accept cycles (minimum) + 3 stall cycles. dbg_wr_en rises 2 cycles after the 4th byte is accepted.
- dbg_addr/dbg_instr change only in BYTE/IDLE/LOAD-accept cycles, never in SETUP/WRITE/HOLD.
- rx_valid gaps are allowed anywhere; the state holds.
- core_rst falls on the clk edge after the RUN byte is accepted.
- Count arithmetic is CNT_W bits unsigned. N=2^CNT_W−1 is legal, and the address wraps silently.

## Structure
- `dbg_loader_pkg`: state enum, command constants (CMD_LOAD, CMD_RUN, CMD_CLR_ERR), WORD_BYTES=4.
- One sub-module is natural: `byte_word_assembler` (byte index counter, little-endian shift into XLEN word, `word_done` pulse). The FSM, counters and address live in `dbg_loader`.

## Test plan
- Reset, then send A5 01 00 B3 81 20 00: one dbg_wr_en pulse with dbg_addr=0, dbg_instr=0x002081B3. core_rst stays 1 and busy returns to 0.
- Load N=4 words (0x002081B3, 0x00310093, 0x002081BB, 0x0031009B), then send 5A: writes at addresses 0, 4, 8, 12 in order. core_rst falls one cycle after 5A is accepted.
- Random rx_valid gaps during the 4-word load: same four writes. rx_ready is 0 for exactly 3 cycles per word, and dbg_wr_en is never high for 2 consecutive cycles.
- Send A5 00 00: no writes, state returns to IDLE. Then send 77: err=1 and the state is unchanged. Then send C3: err=0.
- Deassert rst after the 2nd payload byte of a load: all outputs return to reset values and no write occurs. A fresh load then writes from address 0.
- While in RUN, send A5 01 00 + 4 bytes: core_rst rises on acceptance of A5, the write goes to address 0, and core_rst stays 1 until the next 5A.
